wbsel: RTL

- Write-back stage selector and register-file write driver: the write end of the register file whose read data feeds operand selection.
- Accepts one retiring instruction at a time and selects its result: ALU result, load data from a handshaked data-memory response, or PC+4.
- Sign/zero-extends and aligns load data, then drives a one-cycle register-file write pulse.
- Owns a load-wait state machine with a timeout counter. Stalls upstream while a load is outstanding.

---
 rtl/wbsel.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wbsel.sv
// Write-back selector: picks ALU / load / PC+4 results and drives the
// register-file write port, waiting on a handshaked memory response for loads.
module wbsel #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i_wbsel,
  output logic            ready_o_wbsel,
  input  logic [1:0]      wbsrc_i_wbsel,
  input  logic [4:0]      rd_i_wbsel,
  input  logic [XLEN-1:0] alures_i_wbsel,
  input  logic [XLEN-1:0] pc_i_wbsel,
  input  logic [2:0]      loadop_i_wbsel,
  input  logic            mem_rvalid_i_wbsel,
  input  logic [XLEN-1:0] mem_rdata_i_wbsel,
  output logic            wen_o_wbsel,
  output logic [4:0]      waddr_o_wbsel,
  output logic [XLEN-1:0] wdata_o_wbsel,
  output logic            done_o_wbsel,
  output logic            err_o_wbsel,
  output logic            stall_o_wbsel
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_op;
  logic [2:0]      ld_off;
  logic            load_bad;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ld_val;

  assign ready_o_wbsel = (state == S_IDLE);
  assign stall_o_wbsel = ~ready_o_wbsel;

  // Fault check on the load being presented, evaluated before any memory wait.
  always_comb begin
    load_bad = 1'b0;
    case (loadop_i_wbsel)
      3'b001, 3'b101: load_bad = alures_i_wbsel[0];
      3'b010, 3'b110: load_bad = (alures_i_wbsel[1:0] != 2'b00);
      3'b011:         load_bad = (alures_i_wbsel[2:0] != 3'b000);
      3'b111:         load_bad = 1'b1;
      default:        load_bad = 1'b0;
    endcase
  end

  always_comb begin
    shifted = mem_rdata_i_wbsel >> {ld_off, 3'b000};
    ld_val  = shifted;
    case (ld_op)
      3'b000:  ld_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  ld_val = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  ld_val = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ld_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      ld_rd         <= '0;
      ld_op         <= '0;
      ld_off        <= '0;
      wen_o_wbsel   <= 1'b0;
      done_o_wbsel  <= 1'b0;
      err_o_wbsel   <= 1'b0;
      waddr_o_wbsel <= '0;
      wdata_o_wbsel <= '0;
    end else begin
      wen_o_wbsel  <= 1'b0;
      done_o_wbsel <= 1'b0;
      err_o_wbsel  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i_wbsel) begin
            case (wbsrc_i_wbsel)
              2'd0, 2'd2: begin
                done_o_wbsel <= 1'b1;
                // Address/data only move on a real write so they hold otherwise.
                if (rd_i_wbsel != 5'd0) begin
                  wen_o_wbsel   <= 1'b1;
                  waddr_o_wbsel <= rd_i_wbsel;
                  wdata_o_wbsel <= wbsrc_i_wbsel[1] ? (pc_i_wbsel + XLEN'(4))
                                                    : alures_i_wbsel;
                end
              end
              2'd1: begin
                if (load_bad) begin
                  done_o_wbsel <= 1'b1;
                  err_o_wbsel  <= 1'b1;
                end else begin
                  ld_rd  <= rd_i_wbsel;
                  ld_op  <= loadop_i_wbsel;
                  ld_off <= alures_i_wbsel[2:0];
                  cnt    <= '0;
                  state  <= S_WAIT_MEM;
                end
              end
              default: done_o_wbsel <= 1'b1;
            endcase
          end
        end
        default: begin
          if (mem_rvalid_i_wbsel) begin
            done_o_wbsel <= 1'b1;
            state        <= S_IDLE;
            if (ld_rd != 5'd0) begin
              wen_o_wbsel   <= 1'b1;
              waddr_o_wbsel <= ld_rd;
              wdata_o_wbsel <= ld_val;
            end
          end else if (cnt == CW'(TIMEOUT)) begin
            done_o_wbsel <= 1'b1;
            err_o_wbsel  <= 1'b1;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
